eth_gmii_tx_framer: RTL and testbench

Ethernet transmit framer for the UDP/RGMII send path, clocked by the 125 MHz GMII clock from the PLL. It accepts a byte stream holding one complete MAC frame (destination MAC through end of payload) and drives an 8-bit GMII transmit bus. On that bus it adds the preamble and SFD, pads the frame to the 60-byte minimum, appends the IEEE 802.3 FCS and enforces the inter-frame gap. Its GMII outputs feed the RGMII DDR output stage.

---
 rtl/eth_gmii_tx_framer.sv | 236 +++++++++++++++++++++++
 tb/tb_eth_gmii_tx_framer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_gmii_tx_framer.sv
// GMII transmit framer: wraps a MAC frame byte stream with preamble/SFD,
// pads to the minimum length, appends the 802.3 FCS and enforces the IFG.
module eth_gmii_tx_framer #(
    parameter int IFG_BYTES    = 12,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] tx_frames,
    output logic [15:0] tx_underruns
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        PAD  = 3'd4,
        FCS  = 3'd5,
        DROP = 3'd6,
        IFG  = 3'd7
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
    localparam logic [3:0]  PRE_LEN  = 4'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [3:0]  pre_cnt_r, pre_cnt_nxt_s;
    logic [15:0] byte_cnt_r, byte_cnt_nxt_s;
    logic [2:0]  fcs_idx_r, fcs_idx_nxt_s;
    logic [7:0]  ifg_cnt_r, ifg_cnt_nxt_s;
    logic [31:0] crc_r, crc_nxt_s;
    logic        und_r, und_nxt_s;
    logic [7:0]  txd_r, txd_nxt_s;
    logic        tx_en_r, tx_en_nxt_s;
    logic        tx_er_r, tx_er_nxt_s;
    logic [15:0] tx_frames_r, tx_underruns_r;
    logic        frame_done_s;
    logic [15:0] byte_inc_s;
    logic [31:0] fcs_s;
    logic [7:0]  fcs_byte_s;
    logic        s_ready_s;

    assign byte_inc_s = byte_cnt_r + 16'd1;
    assign fcs_s      = ~crc_r;
    assign s_ready_s  = (state_r == SFD) || (state_r == DATA) || (state_r == DROP);

    // Select the FCS byte for the current FCS slot, least significant byte first.
    always_comb begin
        fcs_byte_s = 8'h00;
        case (fcs_idx_r[1:0])
            2'd0:    fcs_byte_s = fcs_s[7:0];
            2'd1:    fcs_byte_s = fcs_s[15:8];
            2'd2:    fcs_byte_s = fcs_s[23:16];
            default: fcs_byte_s = fcs_s[31:24];
        endcase
    end

    // Next-state and look-ahead output decode; output registers are loaded with
    // the value the wire must show in the cycle that follows this edge.
    always_comb begin
        state_nxt_s    = state_r;
        pre_cnt_nxt_s  = pre_cnt_r;
        byte_cnt_nxt_s = byte_cnt_r;
        fcs_idx_nxt_s  = fcs_idx_r;
        ifg_cnt_nxt_s  = ifg_cnt_r;
        crc_nxt_s      = crc_r;
        und_nxt_s      = 1'b0;
        txd_nxt_s      = 8'h00;
        tx_en_nxt_s    = 1'b0;
        tx_er_nxt_s    = 1'b0;
        frame_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                crc_nxt_s      = CRC_INIT;
                byte_cnt_nxt_s = 16'd0;
                fcs_idx_nxt_s  = 3'd0;
                pre_cnt_nxt_s  = 4'd1;
                if (s_valid) begin
                    state_nxt_s = PRE;
                    txd_nxt_s   = 8'h55;
                    tx_en_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRE: begin
                tx_en_nxt_s = 1'b1;
                if (pre_cnt_r >= PRE_LEN) begin
                    state_nxt_s = SFD;
                    txd_nxt_s   = 8'hD5;
                end else begin
                    txd_nxt_s     = 8'h55;
                    pre_cnt_nxt_s = pre_cnt_r + 4'd1;
                end
            end
            SFD, DATA: begin
                if (s_valid) begin
                    txd_nxt_s      = s_data;
                    tx_en_nxt_s    = 1'b1;
                    crc_nxt_s      = crc32_byte(crc_r, s_data);
                    byte_cnt_nxt_s = (byte_cnt_r < MIN_LEN) ? byte_inc_s : byte_cnt_r;
                    if (s_last) begin
                        state_nxt_s = (byte_inc_s < MIN_LEN) ? PAD : FCS;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    // Source starved mid-frame: flag one error byte, then discard the rest.
                    state_nxt_s = DROP;
                    txd_nxt_s   = 8'h00;
                    tx_en_nxt_s = 1'b1;
                    tx_er_nxt_s = 1'b1;
                    und_nxt_s   = 1'b1;
                end
            end
            PAD: begin
                txd_nxt_s      = 8'h00;
                tx_en_nxt_s    = 1'b1;
                crc_nxt_s      = crc32_byte(crc_r, 8'h00);
                byte_cnt_nxt_s = byte_inc_s;
                if (byte_inc_s >= MIN_LEN) begin
                    state_nxt_s = FCS;
                end else begin
                    state_nxt_s = PAD;
                end
            end
            FCS: begin
                if (fcs_idx_r == 3'd4) begin
                    state_nxt_s   = IFG;
                    frame_done_s  = 1'b1;
                    ifg_cnt_nxt_s = 8'd1;
                end else begin
                    txd_nxt_s     = fcs_byte_s;
                    tx_en_nxt_s   = 1'b1;
                    fcs_idx_nxt_s = fcs_idx_r + 3'd1;
                end
            end
            DROP: begin
                if (s_valid && s_last) begin
                    state_nxt_s   = IFG;
                    ifg_cnt_nxt_s = 8'd1;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            IFG: begin
                if (ifg_cnt_r >= IFG_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    ifg_cnt_nxt_s = ifg_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered GMII outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pre_cnt_r  <= 4'd0;
            byte_cnt_r <= 16'd0;
            fcs_idx_r  <= 3'd0;
            ifg_cnt_r  <= 8'd0;
            crc_r      <= CRC_INIT;
            und_r      <= 1'b0;
            txd_r      <= 8'h00;
            tx_en_r    <= 1'b0;
            tx_er_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pre_cnt_r  <= pre_cnt_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            fcs_idx_r  <= fcs_idx_nxt_s;
            ifg_cnt_r  <= ifg_cnt_nxt_s;
            crc_r      <= crc_nxt_s;
            und_r      <= und_nxt_s;
            txd_r      <= txd_nxt_s;
            tx_en_r    <= tx_en_nxt_s;
            tx_er_r    <= tx_er_nxt_s;
        end
    end

    // Frame and underrun statistics; the underrun count steps as the error byte ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_frames_r    <= 16'd0;
            tx_underruns_r <= 16'd0;
        end else begin
            if (frame_done_s) begin
                tx_frames_r <= tx_frames_r + 16'd1;
            end
            if (und_r) begin
                tx_underruns_r <= tx_underruns_r + 16'd1;
            end
        end
    end

    assign s_ready      = s_ready_s;
    assign busy         = (state_r != IDLE);
    assign gmii_txd     = txd_r;
    assign gmii_tx_en   = tx_en_r;
    assign gmii_tx_er   = tx_er_r;
    assign tx_frames    = tx_frames_r;
    assign tx_underruns = tx_underruns_r;

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Directed bench for eth_gmii_tx_framer: wire bytes are captured on the falling
// edge and compared against frames built by the bench, including a reference CRC-32.
module tb_eth_gmii_tx_framer;

    localparam int PRE_LEN = 7;
    localparam int IFG     = 12;
    localparam int MIN_LEN = 60;

    logic        clk;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [15:0] tx_frames;
    logic [15:0] tx_underruns;

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0]  rx_q[$];
    int          flen_q[$];
    int          fgap_q[$];
    logic [7:0]  exp_q[$];
    int          exp_len_q[$];
    logic [31:0] exp_fcs_q[$];
    int          er_cycles = 0;
    int          idle_bad  = 0;
    int          gap_cnt   = 0;
    int          cur_len   = 0;
    bit          in_frame  = 1'b0;

    eth_gmii_tx_framer #(
        .IFG_BYTES    (IFG),
        .PREAMBLE_LEN (PRE_LEN),
        .MIN_FRAME    (MIN_LEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .gmii_txd     (gmii_txd),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_tx_er   (gmii_tx_er),
        .busy         (busy),
        .tx_frames    (tx_frames),
        .tx_underruns (tx_underruns)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial reflected CRC-32 (one input bit per step).
    function automatic logic [31:0] ref_crc_step(input logic [31:0] r_in, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = r_in;
        for (int b = 0; b < 8; b++) begin
            fb = r[0] ^ d[b];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB8_8320;
        end
        return r;
    endfunction

    // Wire monitor: collects tx_en bytes per frame and the idle gap before each frame.
    initial begin
        forever begin
            @(negedge clk);
            if (gmii_tx_en === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    cur_len  = 0;
                    fgap_q.push_back(gap_cnt);
                end
                rx_q.push_back(gmii_txd);
                cur_len++;
                gap_cnt = 0;
                if (gmii_tx_er === 1'b1) er_cycles++;
            end else begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    flen_q.push_back(cur_len);
                end
                gap_cnt++;
                if (gmii_txd !== 8'h00 || gmii_tx_er !== 1'b0) idle_bad++;
            end
        end
    end

    task automatic drive_byte(input logic [7:0] d, input logic last, output int waited);
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        @(negedge clk);
        waited = 1;
        while (!s_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) check_eq("s_ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input logic [7:0] seed, input bit hold, input bit lat);
        logic [31:0] crc;
        logic [7:0]  d;
        int          waited;
        int          body;
        body = (len < MIN_LEN) ? MIN_LEN : len;
        crc  = 32'hFFFF_FFFF;
        for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < body; i++) begin
            d = (i < len) ? seed + 8'(i) : 8'h00;
            exp_q.push_back(d);
            crc = ref_crc_step(crc, d);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(crc[8*k +: 8]);
        exp_len_q.push_back(PRE_LEN + 1 + body + 4);
        exp_fcs_q.push_back(crc);
        if (lat) begin
            s_data  = seed;
            s_last  = (len == 1);
            s_valid = 1'b1;
            @(negedge clk);
            check_eq("start_idle_en", 32'(gmii_tx_en), 32'd0);
            @(negedge clk);
            check_eq("start_pre_en", 32'(gmii_tx_en), 32'd1);
            check_eq("start_pre_txd", 32'(gmii_txd), 32'h55);
        end
        for (int i = 0; i < len; i++) begin
            drive_byte(seed + 8'(i), (i == len - 1), waited);
            if (lat && i == 0) check_eq("sfd_wait", 32'(waited), 32'(PRE_LEN));
        end
        if (!hold) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = 8'h00;
        end
    endtask

    task automatic check_frame(input string tag, output int gap);
        int          guard;
        int          len;
        int          elen;
        int          bad;
        logic [7:0]  g;
        logic [7:0]  e;
        logic [31:0] fcs_got;
        logic [31:0] fcs_exp;
        guard = 0;
        gap   = -1;
        while (flen_q.size() == 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (flen_q.size() == 0) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        len     = flen_q.pop_front();
        gap     = fgap_q.pop_front();
        elen    = exp_len_q.pop_front();
        fcs_exp = exp_fcs_q.pop_front();
        check_eq({tag, "_len"}, 32'(len), 32'(elen));
        bad     = 0;
        fcs_got = 32'd0;
        for (int i = 0; i < len; i++) begin
            g = rx_q.pop_front();
            if (i < elen) begin
                e = exp_q.pop_front();
                if (g !== e) bad++;
            end else begin
                bad++;
            end
            if (i >= len - 4) fcs_got = {g, fcs_got[31:8]};
        end
        for (int i = len; i < elen; i++) e = exp_q.pop_front();
        check_eq({tag, "_bytes"}, 32'(bad), 32'd0);
        check_eq({tag, "_fcs"}, fcs_got, fcs_exp);
    endtask

    initial begin
        int          gap;
        int          w;
        int          guard;
        int          len;
        int          bad;
        logic [7:0]  g;
        logic [7:0]  e;
        logic [31:0] chk;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;

        // Sanity of the reference CRC against the standard "123456789" vector.
        chk = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) chk = ref_crc_step(chk, 8'h31 + 8'(i));
        if (~chk !== 32'hCBF4_3926) begin
            $display("FAIL ref_crc_model: got 0x%0h", ~chk);
            $fatal(1, "reference CRC broken");
        end

        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(gmii_txd), 32'h00);
        check_eq("rst_tx_en", 32'(gmii_tx_en), 32'd0);
        check_eq("rst_tx_er", 32'(gmii_tx_er), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frames", 32'(tx_frames), 32'd0);
        check_eq("rst_underruns", 32'(tx_underruns), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 64-byte frame: no pad
        send_frame(64, 8'h00, 1'b0, 1'b1);
        check_frame("f64", gap);
        check_eq("f64_frames", 32'(tx_frames), 32'd1);
        check_eq("f64_er", 32'(er_cycles), 32'd0);

        // 14-byte frame: 46 pad bytes
        send_frame(14, 8'hA0, 1'b0, 1'b0);
        check_frame("f14", gap);
        check_eq("f14_frames", 32'(tx_frames), 32'd2);

        // Two 60-byte frames back to back with s_valid held high
        send_frame(60, 8'h40, 1'b1, 1'b0);
        send_frame(60, 8'h80, 1'b0, 1'b0);
        check_frame("b2b_a", gap);
        check_frame("b2b_b", gap);
        check_eq("b2b_gap", 32'(gap), 32'(IFG));
        check_eq("b2b_frames", 32'(tx_frames), 32'd4);

        // Underrun after 20 data bytes, then 10 bytes ending in s_last
        er_cycles = 0;
        for (int i = 0; i < 20; i++) drive_byte(8'h30 + 8'(i), 1'b0, w);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) drive_byte(8'h50 + 8'(i), (i == 9), w);
        s_valid = 1'b0;
        s_last  = 1'b0;
        guard = 0;
        while (flen_q.size() == 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (flen_q.size() == 0) begin
            check_eq("und_frame_timeout", 32'd0, 32'd1);
        end else begin
            len = flen_q.pop_front();
            gap = fgap_q.pop_front();
            check_eq("und_len", 32'(len), 32'(PRE_LEN + 1 + 20 + 1));
            bad = 0;
            for (int i = 0; i < len; i++) begin
                g = rx_q.pop_front();
                if (i < PRE_LEN) e = 8'h55;
                else if (i == PRE_LEN) e = 8'hD5;
                else if (i < PRE_LEN + 21) e = 8'h30 + 8'(i - PRE_LEN - 1);
                else e = 8'h00;
                if (g !== e) bad++;
            end
            check_eq("und_bytes", 32'(bad), 32'd0);
        end
        repeat (20) @(negedge clk);
        check_eq("und_er_cycles", 32'(er_cycles), 32'd1);
        check_eq("und_count", 32'(tx_underruns), 32'd1);
        check_eq("und_frames", 32'(tx_frames), 32'd4);
        check_eq("und_no_extra_frame", 32'(flen_q.size()), 32'd0);
        check_eq("und_idle", 32'(busy), 32'd0);

        send_frame(20, 8'hC0, 1'b0, 1'b0);
        check_frame("post_und", gap);
        check_eq("post_und_frames", 32'(tx_frames), 32'd5);

        // Reset pulse while padding
        send_frame(14, 8'h11, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("pad_busy", 32'(busy), 32'd1);
        check_eq("pad_tx_en", 32'(gmii_tx_en), 32'd1);
        check_eq("pad_txd", 32'(gmii_txd), 32'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx_en", 32'(gmii_tx_en), 32'd0);
        check_eq("mid_rst_tx_er", 32'(gmii_tx_er), 32'd0);
        check_eq("mid_rst_txd", 32'(gmii_txd), 32'h00);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check_eq("mid_rst_frames", 32'(tx_frames), 32'd0);
        check_eq("mid_rst_underruns", 32'(tx_underruns), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        rx_q.delete();
        flen_q.delete();
        fgap_q.delete();
        exp_q.delete();
        exp_len_q.delete();
        exp_fcs_q.delete();
        @(posedge clk);
        #1;

        send_frame(14, 8'h11, 1'b0, 1'b0);
        check_frame("post_rst", gap);
        check_eq("post_rst_frames", 32'(tx_frames), 32'd1);

        // 1-byte frame 0xAB: 59 pad bytes follow
        send_frame(1, 8'hAB, 1'b0, 1'b0);
        check_frame("one_byte", gap);
        check_eq("one_byte_frames", 32'(tx_frames), 32'd2);

        check_eq("idle_txd_zero", 32'(idle_bad), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
